// File: rtl/control_seq.sv
// Instruction sequencer: fetches an instruction word from the bus and decodes it
// into one-hot-low bus-driver/load enables, ALU mode, PC load and flag updates.
module control_seq #(
    parameter int SRC_W = 3,
    parameter int DST_W = 3,
    localparam int IR_W = DST_W + SRC_W + 2
) (
    input  logic                  clk,
    input  logic                  resetBar,
    input  logic [IR_W-1:0]       bus,
    input  logic                  memReady,
    input  logic                  aluZero,
    input  logic                  aluCarry,
    output logic [(1<<SRC_W)-1:0] assertBar,
    output logic [(1<<DST_W)-1:0] loadBar,
    output logic [(1<<DST_W)-1:0] triggerBar,
    output logic                  doSubtract,
    output logic                  doJump,
    output logic                  flagZero,
    output logic                  flagCarry,
    output logic [IR_W-1:0]       ir,
    output logic                  halted,
    output logic                  fetching
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, nextState;

    logic             bit7;
    logic             bit3;
    logic [DST_W-1:0] dest;
    logic [SRC_W-1:0] source;
    logic             memAccess;
    logic             stall;

    assign bit7   = ir[IR_W-1];
    assign dest   = ir[IR_W-2 -: DST_W];
    assign bit3   = ir[SRC_W];
    assign source = ir[SRC_W-1:0];

    // Index 5 on either side is the RAM port; it must wait for memReady.
    assign memAccess = (source == SRC_W'(5)) || (dest == DST_W'(5));
    assign stall     = (state == EXEC) && memAccess && !memReady;

    assign halted   = (state == HALT);
    assign fetching = (state == FETCH);

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state     <= FETCH;
            ir        <= '0;
            flagZero  <= 1'b0;
            flagCarry <= 1'b0;
        end else begin
            state <= nextState;
            if (state == FETCH && memReady) begin
                ir <= bus;
            end
            if (state == EXEC && !stall && dest == DST_W'(2)) begin
                flagZero  <= aluZero;
                flagCarry <= aluCarry;
            end
        end
    end

    always_comb begin
        nextState  = state;
        assertBar  = '1;
        loadBar    = '1;
        triggerBar = '1;
        doSubtract = 1'b0;
        doJump     = 1'b0;
        case (state)
            FETCH: begin
                assertBar[0] = 1'b0;
                loadBar[0]   = 1'b0;
                if (memReady) begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                assertBar[source] = 1'b0;
                if (dest != '0) begin
                    loadBar[dest] = 1'b0;
                end
                doSubtract = bit3;
                doJump     = (dest == DST_W'(1)) &&
                             ((bit3 & flagZero) | (bit7 & flagCarry) | (~bit3 & ~bit7));
                if (!stall) begin
                    // Triggers pulse low during the low half of the completing cycle.
                    triggerBar = loadBar | {(1<<DST_W){clk}};
                    nextState  = (ir == IR_W'(1)) ? HALT : FETCH;
                end
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: default 3/3 build plus a 4/4 build,
// per-cycle expectations queued by stimulus and checked at each falling edge.
module tb_control_seq;

    typedef struct {
        logic        fetching;
        logic        halted;
        logic [15:0] ir;
        logic [15:0] aB;
        logic [15:0] lB;
        logic [15:0] trig;
        logic        dJ;
        logic        dS;
        logic        fZ;
        logic        fC;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic       resetBar = 1'b1;
    logic [7:0] bus = '0;
    logic       memReady = 1'b0;
    logic       aluZero = 1'b0;
    logic       aluCarry = 1'b0;
    logic [7:0] assertBarA, loadBarA, triggerBarA, irA;
    logic       doSubtractA, doJumpA, flagZeroA, flagCarryA, haltedA, fetchingA;

    // Wide build
    logic        resetBarB = 1'b1;
    logic [9:0]  busB = '0;
    logic        memReadyB = 1'b0;
    logic [15:0] assertBarB, loadBarB, triggerBarB;
    logic [9:0]  irB;
    logic        doSubtractB, doJumpB, flagZeroB, flagCarryB, haltedB, fetchingB;

    control_seq uA (
        .clk(clk), .resetBar(resetBar), .bus(bus), .memReady(memReady),
        .aluZero(aluZero), .aluCarry(aluCarry),
        .assertBar(assertBarA), .loadBar(loadBarA), .triggerBar(triggerBarA),
        .doSubtract(doSubtractA), .doJump(doJumpA),
        .flagZero(flagZeroA), .flagCarry(flagCarryA),
        .ir(irA), .halted(haltedA), .fetching(fetchingA)
    );

    control_seq #(.SRC_W(4), .DST_W(4)) uB (
        .clk(clk), .resetBar(resetBarB), .bus(busB), .memReady(memReadyB),
        .aluZero(aluZero), .aluCarry(aluCarry),
        .assertBar(assertBarB), .loadBar(loadBarB), .triggerBar(triggerBarB),
        .doSubtract(doSubtractB), .doJump(doJumpB),
        .flagZero(flagZeroB), .flagCarry(flagCarryB),
        .ir(irB), .halted(haltedB), .fetching(fetchingB)
    );

    int nChecks = 0;
    int nErrors = 0;
    exp_t qA[$];
    exp_t qB[$];

    function automatic exp_t mk(input logic f, input logic h, input logic [15:0] i,
                                input logic [15:0] a, input logic [15:0] l,
                                input logic [15:0] t, input logic j, input logic s,
                                input logic z, input logic c);
        exp_t e;
        e.fetching = f; e.halted = h; e.ir = i; e.aB = a; e.lB = l; e.trig = t;
        e.dJ = j; e.dS = s; e.fZ = z; e.fC = c;
        return e;
    endfunction

    function automatic exp_t fetchA(input logic [15:0] i, input logic z, input logic c);
        return mk(1'b1, 1'b0, i, 16'h00FE, 16'h00FE, 16'h00FF, 1'b0, 1'b0, z, c);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        nChecks++;
        if (act !== expv) begin
            nErrors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic cycA(input logic rb, input logic [7:0] b, input logic mr,
                        input logic az, input logic ac, input exp_t e);
        @(posedge clk);
        #1;
        resetBar = rb; bus = b; memReady = mr; aluZero = az; aluCarry = ac;
        qA.push_back(e);
    endtask

    task automatic cycB(input logic [9:0] b, input logic mr, input exp_t e);
        @(posedge clk);
        #1;
        busB = b; memReadyB = mr;
        qB.push_back(e);
    endtask

    // Monitor: compares the presented outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qA.size() > 0) begin
                e = qA.pop_front();
                chk("A.fetching", 16'(fetchingA), 16'(e.fetching));
                chk("A.halted", 16'(haltedA), 16'(e.halted));
                chk("A.ir", 16'(irA), e.ir);
                chk("A.assertBar", 16'(assertBarA), e.aB);
                chk("A.loadBar", 16'(loadBarA), e.lB);
                chk("A.triggerBarLow", 16'(triggerBarA), e.trig);
                chk("A.doJump", 16'(doJumpA), 16'(e.dJ));
                chk("A.doSubtract", 16'(doSubtractA), 16'(e.dS));
                chk("A.flagZero", 16'(flagZeroA), 16'(e.fZ));
                chk("A.flagCarry", 16'(flagCarryA), 16'(e.fC));
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                chk("B.fetching", 16'(fetchingB), 16'(e.fetching));
                chk("B.halted", 16'(haltedB), 16'(e.halted));
                chk("B.ir", 16'(irB), e.ir);
                chk("B.assertBar", assertBarB, e.aB);
                chk("B.loadBar", loadBarB, e.lB);
                chk("B.triggerBarLow", triggerBarB, e.trig);
                chk("B.doJump", 16'(doJumpB), 16'(e.dJ));
                chk("B.doSubtract", 16'(doSubtractB), 16'(e.dS));
            end
        end
    end

    // While clk is high no trigger may be active.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("A.triggerBarHigh", 16'(triggerBarA), 16'h00FF);
            chk("B.triggerBarHigh", triggerBarB, 16'hFFFF);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        resetBar  = 1'b0;
        resetBarB = 1'b0;
        // Reset state, then plain register move 0x22
        cycA(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, fetchA(16'h00, 1'b0, 1'b0));
        cycA(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, fetchA(16'h00, 1'b0, 1'b0));
        resetBarB = 1'b1;
        cycA(1'b1, 8'h22, 1'b1, 1'b1, 1'b0,
             mk(1'b0, 1'b0, 16'h22, 16'h00FB, 16'h00FB, 16'h00FB, 1'b0, 1'b0, 1'b0, 1'b0));
        cycA(1'b1, 8'h18, 1'b1, 1'b1, 1'b0, fetchA(16'h22, 1'b1, 1'b0));
        // Conditional jump on zero taken
        cycA(1'b1, 8'h18, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 1'b0, 16'h18, 16'h00FE, 16'h00FD, 16'h00FD, 1'b1, 1'b1, 1'b1, 1'b0));
        cycA(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, fetchA(16'h18, 1'b1, 1'b0));
        cycA(1'b1, 8'h22, 1'b1, 1'b0, 1'b1,
             mk(1'b0, 1'b0, 16'h22, 16'h00FB, 16'h00FB, 16'h00FB, 1'b0, 1'b0, 1'b1, 1'b0));
        cycA(1'b1, 8'h18, 1'b1, 1'b0, 1'b1, fetchA(16'h22, 1'b0, 1'b1));
        // Conditional jump on zero not taken
        cycA(1'b1, 8'h90, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 1'b0, 16'h18, 16'h00FE, 16'h00FD, 16'h00FD, 1'b0, 1'b1, 1'b0, 1'b1));
        cycA(1'b1, 8'h90, 1'b1, 1'b0, 1'b0, fetchA(16'h18, 1'b0, 1'b1));
        // Conditional jump on carry taken
        cycA(1'b1, 8'h25, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 1'b0, 16'h90, 16'h00FE, 16'h00FD, 16'h00FD, 1'b1, 1'b0, 1'b0, 1'b1));
        cycA(1'b1, 8'h25, 1'b1, 1'b0, 1'b0, fetchA(16'h90, 1'b0, 1'b1));
        // RAM read stalled three cycles; flags must not move
        for (int i = 0; i < 3; i++) begin
            cycA(1'b1, 8'h25, 1'b0, 1'b1, 1'b0,
                 mk(1'b0, 1'b0, 16'h25, 16'h00DF, 16'h00FB, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        cycA(1'b1, 8'h25, 1'b1, 1'b1, 1'b0,
             mk(1'b0, 1'b0, 16'h25, 16'h00DF, 16'h00FB, 16'h00FB, 1'b0, 1'b0, 1'b0, 1'b1));
        cycA(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, fetchA(16'h25, 1'b1, 1'b0));
        // HALT instruction
        cycA(1'b1, 8'h01, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 1'b0, 16'h01, 16'h00FD, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 12; i++) begin
            cycA(1'b1, 8'h01, 1'b1, 1'b0, 1'b0,
                 mk(1'b0, 1'b1, 16'h01, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        // Reset pulse leaves HALT
        cycA(1'b0, 8'h25, 1'b1, 1'b0, 1'b0, fetchA(16'h00, 1'b0, 1'b0));
        cycA(1'b1, 8'h25, 1'b1, 1'b0, 1'b0, fetchA(16'h00, 1'b0, 1'b0));
        cycA(1'b1, 8'h25, 1'b0, 1'b1, 1'b1,
             mk(1'b0, 1'b0, 16'h25, 16'h00DF, 16'h00FB, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0));
        // Asynchronous reset in the middle of a stall, no clock edge before the check
        @(posedge clk);
        #1;
        memReady = 1'b0;
        qA.push_back(fetchA(16'h00, 1'b0, 1'b0));
        #1;
        resetBar = 1'b0;
        cycA(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, fetchA(16'h00, 1'b0, 1'b0));
        cycA(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, fetchA(16'h00, 1'b0, 1'b0));
        // Wide build: dest 12, source 9
        cycB(10'h189, 1'b1,
             mk(1'b1, 1'b0, 16'h000, 16'hFFFE, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
        cycB(10'h189, 1'b1,
             mk(1'b0, 1'b0, 16'h189, 16'hFDFF, 16'hEFFF, 16'hEFFF, 1'b0, 1'b0, 1'b0, 1'b0));
        cycB(10'h000, 1'b0,
             mk(1'b1, 1'b0, 16'h189, 16'hFFFE, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        #1;
        chk("A.queueDrained", 16'(qA.size()), 16'h0000);
        chk("B.queueDrained", 16'(qB.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 The module SHALL expose parameter SRC_W, default 3, source-field width; legal values 3..4.
REQ-002 The module SHALL expose parameter DST_W, default 3, destination-field width; legal values 3..4.
REQ-003 IR_W SHALL equal DST_W+SRC_W+2 (8 at defaults); IR layout {bit7, dest[DST_W-1:0], bit3, source[SRC_W-1:0]}.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 resetBar  input  1  reset, asynchronous, active-low.
REQ-006 bus  input  IR_W  data bus, sampled into the IR.
REQ-007 memReady  input  1  memory handshake; 1 = ROM/RAM access completes this cycle.
REQ-008 aluZero, aluCarry  input  1 each  ALU result flags.
REQ-009 assertBar  output  2**SRC_W  one-hot-low bus-driver enables, index = source.
REQ-010 loadBar  output  2**DST_W  one-hot-low load enables, index = dest.
REQ-011 triggerBar  output  2**DST_W  clock-qualified register triggers.
REQ-012 doSubtract, doJump  output  1 each  ALU mode; PC load.
REQ-013 flagZero, flagCarry  output  1 each  registered flags.
REQ-014 ir  output  IR_W  current instruction.
REQ-015 halted  output  1  high in the HALT state.
REQ-016 fetching  output  1  high in the FETCH state.

Function
REQ-017 The state machine SHALL have the states FETCH, EXEC and HALT.
REQ-018 FETCH: assertBar[0]=0 (ROM) and loadBar[0]=0; all other bits high; on a rising edge with memReady=1, ir<=bus and the state goes to EXEC; with memReady=0 the state stays FETCH.
REQ-019 EXEC decode: assertBar[source]=0 and loadBar[dest]=0, except dest==0, which SHALL drive no load (NOP).
REQ-020 EXEC memory stall: if source==5 or dest==5 and memReady=0, the state SHALL stay EXEC with all outputs held; otherwise the next state is FETCH.
REQ-021 triggerBar[d] SHALL equal ~(~clk & ~loadBar[d]) only in EXEC while not stalled; otherwise it SHALL be all ones.
REQ-022 doSubtract SHALL equal bit3 in EXEC and 0 otherwise.
REQ-023 doJump SHALL be asserted in EXEC when dest==1 and any of these conditions holds:
- bit3 & flagZero;
- bit7 & flagCarry;
- ~bit3 & ~bit7 (unconditional).
REQ-024 The flags SHALL change only on the completing EXEC edge (not stalled) with dest==2: flagZero<=aluZero and flagCarry<=aluCarry; at all other times they hold.
REQ-025 The jump condition SHALL use the registered flags, so a flag written by instruction N is visible to instruction N+1 and later.
REQ-026 An EXEC with ir equal to 1 (dest 0, source 1) SHALL enter HALT on the next edge.
REQ-027 HALT: assertBar, loadBar and triggerBar all ones; doJump=0; halted=1; HALT is left only by reset.
REQ-028 Decode bits beyond the implemented sources/destinations SHALL produce no assert or load.
REQ-029 Latency: 2 cycles per instruction with no stalls; each stall cycle adds exactly 1.

Reset
REQ-030 While resetBar=0, and immediately on its assertion, the block SHALL be in this state:
- state=FETCH, ir=0, flagZero=0, flagCarry=0, halted=0, fetching=1;
- triggerBar all ones; doJump=0; doSubtract=0.
REQ-031 Reset asserted mid-stall or in HALT SHALL abort the operation; after release the first rising edge evaluates FETCH.
REQ-032 Release of resetBar SHALL be synchronised externally; the block needs no internal synchroniser.

Verification
REQ-033 Reset, then bus=0x22 (dest 2, source 2) with memReady=1 -> cycle 1: fetching=1 and assertBar[0]=0; cycle 2: loadBar[2]=0, assertBar[2]=0, triggerBar[2] low while clk is low; back in FETCH.
REQ-034 Execute dest 2 with aluZero=1, then fetch 0x18 (dest 1, bit3) -> doJump=1; repeat with aluZero=0 -> doJump=0.
REQ-035 Execute 0x25 (dest 2, source 5, RAM) with memReady=0 for 3 cycles -> EXEC held 3 cycles, triggerBar all ones, flags unchanged; completes in the cycle memReady=1.
REQ-036 Fetch 0x01 -> halted=1 and all enables inactive for 10+ cycles; resetBar pulse low -> fetching=1, ir=0.
REQ-037 Assert resetBar=0 mid-cycle during an EXEC stall -> outputs take reset values without a clock edge.
REQ-038 Build with SRC_W=4, DST_W=4 (IR_W=10): fetch dest 12, source 9 -> loadBar[12]=0 and assertBar[9]=0; all other enable bits high.
